// File: rtl/icache_fetch_ctrl.sv
// Direct-mapped instruction-fetch cache controller.
// Critical-word-first line refill, optional next-line prefetch, flush, stats.
module icache_fetch_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int PREFETCH   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 proc_valid,
    output logic                 proc_ready,
    input  logic [31:0]          proc_addr,
    output logic [31:0]          proc_rdata,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [31:0]          mem_req_addr,
    input  logic [31:0]          mem_req_rdata,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int OFF  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = 30 - OFF - IDX;
    localparam int LNW  = 30 - OFF;
    localparam logic [OFF:0] LAST_BEAT = (OFF + 1)'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_DONE,
        S_PREF
    } state_t;

    state_t state_q, state_d;

    logic [29:0]          req_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAGW-1:0]      tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];
    logic                 flush_pend_q;
    logic                 from_refill_q;
    logic [OFF-1:0]       ptr_q;
    logic [OFF:0]         cnt_q;
    logic [IDX-1:0]       fill_idx_q;
    logic [TAGW-1:0]      fill_tag_q;

    logic [OFF-1:0]  req_off;
    logic [IDX-1:0]  req_idx;
    logic [TAGW-1:0] req_tag;
    logic [LNW-1:0]  nxt_line;
    logic [IDX-1:0]  nxt_idx;
    logic [TAGW-1:0] nxt_tag;
    logic [OFF-1:0]  ptr_nxt;
    logic            hit;
    logic            nxt_present;
    logic            beat;
    logic            last_beat;
    logic            do_flush;
    logic            unused_addr_bits;

    assign req_off  = req_q[OFF-1:0];
    assign req_idx  = req_q[OFF+IDX-1:OFF];
    assign req_tag  = req_q[29:OFF+IDX];
    assign nxt_line = req_q[29:OFF] + LNW'(1);
    assign nxt_idx  = nxt_line[IDX-1:0];
    assign nxt_tag  = nxt_line[LNW-1:IDX];
    assign ptr_nxt  = ptr_q + OFF'(1);

    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign nxt_present = valid_q[nxt_idx] && (tag_q[nxt_idx] == nxt_tag);
    assign beat        = mem_req_valid && mem_req_ready;
    assign last_beat   = beat && (cnt_q == LAST_BEAT);
    assign do_flush    = (state_q == S_IDLE) && (flush || flush_pend_q);

    assign unused_addr_bits = ^proc_addr[1:0];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (!do_flush && proc_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = hit ? S_DONE : S_REFILL;
            S_REFILL: if (last_beat) state_d = S_DONE;
            S_DONE: begin
                if ((PREFETCH != 0) && from_refill_q && !nxt_present)
                    state_d = S_PREF;
                else
                    state_d = S_IDLE;
            end
            S_PREF:   if (last_beat) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Line storage: data beats and tag written as the fill progresses.
    always_ff @(posedge clk) begin
        if (beat) begin
            data_q[{fill_idx_q, ptr_q}] <= mem_req_rdata;
            if (last_beat) tag_q[fill_idx_q] <= fill_tag_q;
        end
    end

    // Control datapath: valid bits, fill pointers, outputs and counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q         <= '0;
            valid_q       <= '0;
            flush_pend_q  <= 1'b0;
            from_refill_q <= 1'b0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            fill_idx_q    <= '0;
            fill_tag_q    <= '0;
            proc_ready    <= 1'b0;
            proc_rdata    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            proc_ready <= 1'b0;
            if (flush && (state_q != S_IDLE)) flush_pend_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (do_flush) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (proc_valid) begin
                        req_q <= proc_addr[31:2];
                    end
                end
                S_LOOKUP: begin
                    from_refill_q <= 1'b0;
                    if (hit) begin
                        proc_ready <= 1'b1;
                        proc_rdata <= data_q[{req_idx, req_off}];
                        if (hit_count != '1)
                            hit_count <= hit_count + CNT_WIDTH'(1);
                    end else begin
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_WIDTH'(1);
                        valid_q[req_idx] <= 1'b0;
                        fill_idx_q       <= req_idx;
                        fill_tag_q       <= req_tag;
                        ptr_q            <= req_off;
                        cnt_q            <= '0;
                        mem_req_valid    <= 1'b1;
                        mem_req_addr     <= {req_q, 2'b00};
                    end
                end
                S_REFILL, S_PREF: begin
                    if (beat) begin
                        ptr_q        <= ptr_nxt;
                        cnt_q        <= cnt_q + (OFF + 1)'(1);
                        mem_req_addr <= {fill_tag_q, fill_idx_q, ptr_nxt, 2'b00};
                        if ((state_q == S_REFILL) && (cnt_q == '0))
                            proc_rdata <= mem_req_rdata;
                        if (last_beat) begin
                            valid_q[fill_idx_q] <= 1'b1;
                            mem_req_valid       <= 1'b0;
                            if (state_q == S_REFILL) begin
                                proc_ready    <= 1'b1;
                                from_refill_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (state_d == S_PREF) begin
                        valid_q[nxt_idx] <= 1'b0;
                        fill_idx_q       <= nxt_idx;
                        fill_tag_q       <= nxt_tag;
                        ptr_q            <= '0;
                        cnt_q            <= '0;
                        mem_req_valid    <= 1'b1;
                        mem_req_addr     <= {nxt_line, {OFF{1'b0}}, 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl: default, prefetch and
// narrow-counter instances driven one at a time.
module tb_icache_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic [31:0] paddr;
    logic        rdy;
    logic        flush;
    logic        flush_off;

    logic        pv  [3];
    logic        pr  [3];
    logic [31:0] prd [3];
    logic        mv  [3];
    logic [31:0] ma  [3];
    logic [31:0] rd  [3];

    logic [15:0] hc0, mc0, hc1, mc1;
    logic [1:0]  hc2, mc2;

    logic [31:0] bq0[$];
    logic [31:0] bq1[$];
    logic [31:0] bq2[$];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd[0] = (ma[0] >> 2) + 32'h100;
    assign rd[1] = (ma[1] >> 2) + 32'h100;
    assign rd[2] = (ma[2] >> 2) + 32'h100;

    icache_fetch_ctrl u0 (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[0]), .proc_ready(pr[0]),
        .proc_addr(paddr), .proc_rdata(prd[0]),
        .mem_req_valid(mv[0]), .mem_req_ready(rdy),
        .mem_req_addr(ma[0]), .mem_req_rdata(rd[0]),
        .flush(flush), .hit_count(hc0), .miss_count(mc0)
    );

    icache_fetch_ctrl #(.PREFETCH(1)) u1 (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[1]), .proc_ready(pr[1]),
        .proc_addr(paddr), .proc_rdata(prd[1]),
        .mem_req_valid(mv[1]), .mem_req_ready(rdy),
        .mem_req_addr(ma[1]), .mem_req_rdata(rd[1]),
        .flush(flush_off), .hit_count(hc1), .miss_count(mc1)
    );

    icache_fetch_ctrl #(.CNT_WIDTH(2)) u2 (
        .clk(clk), .resetn(resetn),
        .proc_valid(pv[2]), .proc_ready(pr[2]),
        .proc_addr(paddr), .proc_rdata(prd[2]),
        .mem_req_valid(mv[2]), .mem_req_ready(rdy),
        .mem_req_addr(ma[2]), .mem_req_rdata(rd[2]),
        .flush(flush_off), .hit_count(hc2), .miss_count(mc2)
    );

    // Log every accepted memory beat address per instance.
    always @(posedge clk) begin
        if (mv[0] && rdy) bq0.push_back(ma[0]);
        if (mv[1] && rdy) bq1.push_back(ma[1]);
        if (mv[2] && rdy) bq2.push_back(ma[2]);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch; lat counts edges from the sampling edge to proc_ready.
    task automatic do_req(input int i, input logic [31:0] a,
                          input bit stall, input int flush_at,
                          output int lat, output logic [31:0] data);
        bit got;
        got  = 1'b0;
        lat  = 0;
        data = '0;
        @(negedge clk);
        paddr = a;
        pv[i] = 1'b1;
        rdy   = stall ? 1'b0 : 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (flush_at != 0) flush = (lat == flush_at);
            if (stall) rdy = (lat % 2 == 1);
            if (pr[i]) begin
                got  = 1'b1;
                data = prd[i];
            end
        end
        pv[i] = 1'b0;
        flush = 1'b0;
        rdy   = 1'b1;
        check($sformatf("resp_seen_%h", a), 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic req_chk(input int i, input string tag,
                           input logic [31:0] a, input bit stall,
                           input int flush_at, input int exp_lat,
                           input logic [31:0] exp_data);
        int lat;
        logic [31:0] data;
        do_req(i, a, stall, flush_at, lat, data);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, data, exp_data);
    endtask

    initial begin
        int n;
        resetn    = 1'b0;
        paddr     = '0;
        rdy       = 1'b1;
        flush     = 1'b0;
        flush_off = 1'b0;
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(pr[0]), 32'd0);
        check("rst_rdata", prd[0], 32'd0);
        check("rst_mvalid", 32'(mv[0]), 32'd0);
        check("rst_maddr", ma[0], 32'd0);
        check("rst_hits", 32'(hc0), 32'd0);
        check("rst_misses", 32'(mc0), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Cold miss, critical word first.
        req_chk(0, "cold", 32'h08, 1'b0, 0, 6, 32'h102);
        check("cold_nbeats", 32'(bq0.size()), 32'd4);
        check("cold_b0", bq0[0], 32'h08);
        check("cold_b1", bq0[1], 32'h0C);
        check("cold_b2", bq0[2], 32'h00);
        check("cold_b3", bq0[3], 32'h04);
        check("cold_miss", 32'(mc0), 32'd1);

        // Hits.
        req_chk(0, "hit08", 32'h08, 1'b0, 0, 2, 32'h102);
        req_chk(0, "hit00", 32'h00, 1'b0, 0, 2, 32'h100);
        check("hit_nobeats", 32'(bq0.size()), 32'd4);
        check("hit_count", 32'(hc0), 32'd2);
        check("hit_misses", 32'(mc0), 32'd1);

        // Conflict with memory stalls, then old tag misses again.
        req_chk(0, "conf", 32'h100, 1'b1, 0, 10, 32'h140);
        check("conf_nbeats", 32'(bq0.size()), 32'd8);
        check("conf_b0", bq0[4], 32'h100);
        check("conf_b3", bq0[7], 32'h10C);
        req_chk(0, "remiss00", 32'h00, 1'b0, 0, 6, 32'h100);
        check("remiss_miss", 32'(mc0), 32'd3);

        // Flush during refill; applied in the following idle cycle.
        req_chk(0, "flref", 32'h40, 1'b0, 3, 6, 32'h110);
        req_chk(0, "flre", 32'h40, 1'b0, 0, 7, 32'h110);
        req_chk(0, "flother", 32'h08, 1'b0, 0, 6, 32'h102);
        check("fl_miss", 32'(mc0), 32'd6);
        check("fl_hits", 32'(hc0), 32'd2);

        // Prefetch instance.
        req_chk(1, "pf_dem", 32'h10, 1'b0, 0, 6, 32'h104);
        n = 0;
        while (bq1.size() < 8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pf_nbeats", 32'(bq1.size()), 32'd8);
        check("pf_d0", bq1[0], 32'h10);
        check("pf_p0", bq1[4], 32'h20);
        check("pf_p1", bq1[5], 32'h24);
        check("pf_p2", bq1[6], 32'h28);
        check("pf_p3", bq1[7], 32'h2C);
        check("pf_mvalid_idle", 32'(mv[1]), 32'd0);
        req_chk(1, "pf_hit24", 32'h24, 1'b0, 0, 2, 32'h109);
        check("pf_miss", 32'(mc1), 32'd1);
        check("pf_hits", 32'(hc1), 32'd1);
        req_chk(1, "pf_m00", 32'h00, 1'b0, 0, 6, 32'h100);
        repeat (8) @(posedge clk);
        #1;
        check("pf_skip_present", 32'(bq1.size()), 32'd12);
        check("pf_miss2", 32'(mc1), 32'd2);

        // Saturating 2-bit counters.
        req_chk(2, "sat_m", 32'h08, 1'b0, 0, 6, 32'h102);
        for (int j = 0; j < 3; j++)
            req_chk(2, "sat_h", 32'h08, 1'b0, 0, 2, 32'h102);
        check("sat_hits3", 32'(hc2), 32'd3);
        for (int j = 0; j < 2; j++)
            req_chk(2, "sat_h", 32'h08, 1'b0, 0, 2, 32'h102);
        check("sat_hits5", 32'(hc2), 32'd3);
        check("sat_miss", 32'(mc2), 32'd1);

        // Reset after the second beat of a refill.
        n = bq0.size();
        @(negedge clk);
        paddr = 32'h200;
        pv[0] = 1'b1;
        rdy   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        pv[0]  = 1'b0;
        #1;
        check("mrst_nbeats", 32'(bq0.size() - n), 32'd2);
        check("mrst_b0", bq0[n], 32'h200);
        check("mrst_b1", bq0[n+1], 32'h204);
        check("mrst_ready", 32'(pr[0]), 32'd0);
        check("mrst_rdata", prd[0], 32'd0);
        check("mrst_mvalid", 32'(mv[0]), 32'd0);
        check("mrst_maddr", ma[0], 32'd0);
        check("mrst_hits", 32'(hc0), 32'd0);
        check("mrst_misses", 32'(mc0), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        req_chk(0, "post200", 32'h200, 1'b0, 0, 6, 32'h180);
        req_chk(0, "post40", 32'h40, 1'b0, 0, 6, 32'h110);
        check("post_miss", 32'(mc0), 32'd2);
        check("post_hits", 32'(hc0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_fetch_ctrl.md
# icache_fetch_ctrl

Parametrised direct-mapped instruction-fetch cache controller between the core fetch port and the instruction memory port. It serves 32-bit instruction words from a register-based cache of `NUM_LINES` lines × `LINE_WORDS` words. Misses are refilled with multi-beat, critical-word-first line fills. Optional features:
- next-line prefetch;
- a flush request;
- saturating hit/miss counters used for compression-study statistics.

## Interface
Parameters:
- `NUM_LINES`, 16, number of cache lines; power of 2, ≥2.
- `LINE_WORDS`, 4, 32-bit words per line; power of 2, ≥2.
- `PREFETCH`, 0, 1 enables next-line prefetch after a demand refill.
- `CNT_WIDTH`, 16, width of the hit/miss counters.

Ports:
- `clk` input 1 — single clock; all state updates on the rising edge.
- `resetn` input 1 — asynchronous, active-low reset.
- `proc_valid` input 1 — fetch request; held with `proc_addr` until `proc_ready`.
- `proc_ready` output 1 — one-cycle pulse; `proc_rdata` is valid in the same cycle.
- `proc_addr` input 32 — byte address; bits [1:0] are ignored.
- `proc_rdata` output 32 — fetched instruction word.
- `mem_req_valid` output 1 — memory beat request.
- `mem_req_ready` input 1 — memory accepts the beat; `mem_req_rdata` is valid in that cycle.
- `mem_req_addr` output 32 — word-aligned beat address.
- `mem_req_rdata` input 32 — beat data.
- `flush` input 1 — single-cycle pulse; invalidates all lines.
- `hit_count` output `CNT_WIDTH` — demand hits, saturating.
- `miss_count` output `CNT_WIDTH` — demand misses, saturating.

## Operation
- **Address split.**
  - OFF = log2(`LINE_WORDS`), IDX = log2(`NUM_LINES`).
  - Word offset = addr[OFF+1:2].
  - Index = addr[OFF+IDX+1:OFF+2].
  - Tag = addr[31:OFF+IDX+2].
- **Storage.** Per line: valid bit, tag, `LINE_WORDS` data words.
- **IDLE**
  - If `flush_pend` is set: clear all valid bits and `flush_pend`, stay in IDLE; `proc_valid` is not sampled this cycle.
  - Otherwise, if `proc_valid`: latch `proc_addr` and go to LOOKUP.
- **LOOKUP**
  - Compare the latched request against the indexed line.
  - Hit (valid and tag match): increment `hit_count`, load `proc_rdata` from the line, go to DONE.
  - Miss: increment `miss_count`, set beat pointer = requested offset, go to REFILL.
- **REFILL**
  - Hold `mem_req_valid`=1 with `mem_req_addr` = {tag, index, beat pointer, 2'b00}.
  - On each cycle with `mem_req_valid` && `mem_req_ready`:
    - write `mem_req_rdata` into the line at the beat pointer;
    - if this is the first beat, capture it into `proc_rdata`;
    - advance the beat pointer by 1, modulo `LINE_WORDS` (critical-word-first, wrap within line).
  - After `LINE_WORDS` beats: set the line's valid bit and tag, drop `mem_req_valid`, go to DONE.
  - The line stays invalid during refill; the old line content is lost as soon as the first beat is written.
- **DONE**
  - Assert `proc_ready` for exactly one cycle; `proc_valid` is ignored in this cycle.
  - Next state: if `PREFETCH`=1 and DONE was reached from REFILL and line index+1 (mod `NUM_LINES`) does not already hold tag' → PREFETCH.
    - tag' is the tag of addr + one line; it increments if the index wraps.
  - Otherwise → IDLE.
- **PREFETCH**
  - Same beat protocol as REFILL, starting at offset 0, for line index+1 / tag'.
  - Sets valid on completion, then goes to IDLE.
  - Not counted as a miss. A later demand hit on a prefetched line counts as a hit.
- **Flush.**
  - `flush` asserted in IDLE takes effect in that cycle; a simultaneous `proc_valid` is deferred by one cycle.
  - `flush` asserted in any other state sets `flush_pend`, which is applied in the first following IDLE cycle.
  - A line being refilled when the flush is applied ends invalid.
- **Counters.** Saturate at all-ones and never wrap.
- **Reset** (`resetn`=0, at any time, including mid-refill):
  - state = IDLE; all valid bits = 0; `flush_pend` = 0;
  - `proc_ready` = 0; `proc_rdata` = 0; `mem_req_valid` = 0; `mem_req_addr` = 0;
  - `hit_count` = 0; `miss_count` = 0.
  - An in-flight beat is dropped. Data array contents are don't-care.

## Timing
- `proc_valid` is sampled in IDLE at edge k; LOOKUP occupies cycle k+1.
- Hit: `proc_ready` is high in cycle k+2.
- Miss with `mem_req_ready` held high: beats in cycles k+2 … k+1+`LINE_WORDS`, `proc_ready` in cycle k+2+`LINE_WORDS` (k+6 for the default).
  - Each memory stall cycle (`mem_req_ready`=0) adds one cycle.
- `mem_req_addr` is stable while `mem_req_valid`=1 and changes only on the edge following a handshake.
- `mem_req_valid` is never deasserted mid-line except by reset.
- All outputs are registered; there is no combinational path from `proc_*` or `mem_req_ready` to any output.
- Back-to-back requests:
  - the next request is sampled no earlier than the cycle after DONE;
  - with PREFETCH active, it is sampled no earlier than the cycle after the prefetch's last beat.

## Test plan
- **Cold miss.** Reset; request 0x00000008; memory returns addr>>2 + 0x100 with ready tied high.
  - Beat addresses 0x08, 0x0C, 0x00, 0x04.
  - `proc_ready` at k+6 with `proc_rdata`=0x102; `miss_count`=1.
- **Hit.** Repeat 0x00000008, then 0x00000000.
  - Each gets `proc_ready` at k+2 with 0x102 / 0x100 and no `mem_req_valid`; `hit_count`=2.
- **Conflict and stall.** Request 0x00000100 (same index, new tag) with ready toggling every other cycle.
  - Refill with stalls; `proc_ready` at k+10 with 0x140.
  - 0x00000000 then misses again.
- **Prefetch** (`PREFETCH`=1). Miss on 0x00000010.
  - After DONE, beats 0x20, 0x24, 0x28, 0x2C are issued.
  - 0x00000024 then hits with 0x109; `miss_count` rises by 1, not 2.
- **Flush.** Pulse `flush` during a refill.
  - Refill completes and responds.
  - Flush is applied in the next IDLE cycle; a re-request to the same address misses.
- **Reset mid-refill, then saturation.**
  - Deassert `resetn` after the 2nd beat: all outputs return to reset values immediately, and a re-request misses.
  - With `CNT_WIDTH`=2, 5 hits leave `hit_count`=3.
